// File: rtl/sparse_pos_streamer_pkg.sv
// ---------------------------------------------------------------------------
// sparse_pos_streamer_pkg
//   Shared definitions for the sparse position streamer:
//     - default geometry (polynomial length, RAM depth, dummy stride)
//     - FSM state encoding (IDLE, PAD, RD, OUT)
//     - RAM entry layout: {dummy, pos}, with the dummy flag at the MSB
// ---------------------------------------------------------------------------
package sparse_pos_streamer_pkg;

    localparam int unsigned DEF_N            = 17669;
    localparam int unsigned DEF_MAX_WEIGHT   = 75;
    localparam int unsigned DEF_DUMMY_STRIDE = 263;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAD  = 2'd1,
        ST_RD   = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // A RAM entry is one position plus the dummy flag above it.
    function automatic int unsigned entry_width(input int unsigned logn);
        return logn + 1;
    endfunction

endpackage

// File: rtl/mem_single.sv
// ---------------------------------------------------------------------------
// mem_single
//   Single-port synchronous RAM with a one-cycle registered read.
//   Ports:
//     clk    : clock
//     we     : write enable (writes wdata at addr)
//     re     : read enable (rdata <= mem[addr] on the next edge)
//     addr   : shared read/write address
//     wdata  : write data
//     rdata  : registered read data, held while re is low
// ---------------------------------------------------------------------------
module mem_single #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array or the read register: validity is tracked by
    // the owner, and rdata holding its value lets the owner keep outputs
    // stable while it waits.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sparse_pos_streamer.sv
// ---------------------------------------------------------------------------
// sparse_pos_streamer
//   Collects up to MAX_WEIGHT sparse positions from the host, pads the
//   remaining RAM slots with deterministic dummy positions on start, and
//   streams exactly MAX_WEIGHT {dummy,pos} entries to the multiplier.
//
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     clr_i           : zero count and error flag (IDLE only)
//     load_valid_i/load_ready_o/load_pos_i : position load channel
//     start_i, seed_i : begin pad+stream; seed_i is the first dummy position
//     out_valid_o/out_ready_i/out_pos_o/out_dummy_o/out_last_o : stream
//     count_o         : number of real positions stored
//     busy_o          : FSM not in IDLE
//     done_o          : one-cycle pulse after the last stream handshake
//     err_o           : sticky, set when an out-of-range load is rejected
//     dbg_state       : current FSM state
//
//   Handshakes (both channels): a transfer happens on a rising edge where
//   valid and ready are both high. The stream side holds valid and all
//   payload bits stable until that transfer; the load side's ready never
//   depends on load_valid_i.
// ---------------------------------------------------------------------------
module sparse_pos_streamer
    import sparse_pos_streamer_pkg::*;
#(
    parameter int unsigned N              = DEF_N,
    parameter int unsigned MAX_WEIGHT     = DEF_MAX_WEIGHT,
    parameter int unsigned DUMMY_STRIDE   = DEF_DUMMY_STRIDE,
    parameter int unsigned LOGN           = $clog2(N),
    parameter int unsigned LOG_MAX_WEIGHT = $clog2(MAX_WEIGHT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_i,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    input  logic [LOGN-1:0]           load_pos_i,
    input  logic                      start_i,
    input  logic [LOGN-1:0]           seed_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LOGN-1:0]           out_pos_o,
    output logic                      out_dummy_o,
    output logic                      out_last_o,
    output logic [LOG_MAX_WEIGHT-1:0] count_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output state_t                    dbg_state
);

    localparam int unsigned ENTRY_W = entry_width(LOGN);

    // N and the stride are held one bit wider than a position so that N
    // itself, and position+stride, are always representable.
    localparam logic [LOGN:0]           N_EXT      = (LOGN + 1)'(N);
    localparam logic [LOGN:0]           STRIDE_EXT = (LOGN + 1)'(DUMMY_STRIDE);
    localparam logic [LOG_MAX_WEIGHT-1:0] MW_CNT   = LOG_MAX_WEIGHT'(MAX_WEIGHT);
    localparam logic [LOG_MAX_WEIGHT-1:0] LAST_IDX = LOG_MAX_WEIGHT'(MAX_WEIGHT - 1);

    state_t                    state;
    logic [LOG_MAX_WEIGHT-1:0] count;
    logic [LOG_MAX_WEIGHT-1:0] pad_idx;
    logic [LOG_MAX_WEIGHT-1:0] rd_idx;
    logic [LOGN-1:0]           dummy;
    logic                      err;
    logic                      done;

    logic                      load_ready;
    logic                      load_fire;
    logic                      in_range;
    logic                      pad_we;
    logic [LOGN:0]             dummy_sum;
    logic [LOGN-1:0]           dummy_next;

    logic                      mem_we;
    logic                      mem_re;
    logic [LOG_MAX_WEIGHT-1:0] mem_addr;
    logic [ENTRY_W-1:0]        mem_wdata;
    logic [ENTRY_W-1:0]        mem_rdata;

    always_comb begin
        load_ready = (state == ST_IDLE) && (count < MW_CNT) && !start_i && !clr_i;
        load_fire  = load_valid_i && load_ready;
        in_range   = ({1'b0, load_pos_i} < N_EXT);

        // Slots are written only while the pad index is still inside the
        // RAM; a full RAM enters PAD with pad_idx == MAX_WEIGHT.
        pad_we     = (state == ST_PAD) && (pad_idx < MW_CNT);

        // Modular step: both operands are < N, so one subtract suffices.
        dummy_sum  = {1'b0, dummy} + STRIDE_EXT;
        dummy_next = dummy_sum[LOGN-1:0];
        if (dummy_sum >= N_EXT) begin
            dummy_next = LOGN'(dummy_sum - N_EXT);
        end

        mem_we    = (load_fire && in_range) || pad_we;
        mem_re    = (state == ST_RD);
        mem_addr  = rd_idx;
        mem_wdata = {1'b0, load_pos_i};
        if (state == ST_IDLE) begin
            mem_addr = count;
        end else if (state == ST_PAD) begin
            mem_addr  = pad_idx;
            mem_wdata = {1'b1, dummy};
        end
    end

    mem_single #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (MAX_WEIGHT),
        .ADDR_W (LOG_MAX_WEIGHT)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            pad_idx <= '0;
            rd_idx  <= '0;
            dummy   <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_i) begin
                        count <= '0;
                        err   <= 1'b0;
                    end else if (start_i) begin
                        state   <= ST_PAD;
                        dummy   <= seed_i;
                        pad_idx <= count;
                    end else if (load_fire) begin
                        // Out-of-range positions complete the handshake but
                        // leave the RAM and count untouched.
                        if (in_range) begin
                            count <= count + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    if (pad_we) begin
                        dummy   <= dummy_next;
                        pad_idx <= pad_idx + 1'b1;
                    end
                    if (pad_idx >= LAST_IDX) begin
                        state  <= ST_RD;
                        rd_idx <= '0;
                    end
                end
                ST_RD: begin
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        if (rd_idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                            state  <= ST_RD;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stream payload is gated by the state so it reads as zero outside OUT
    // (the RAM read register itself is not reset).
    assign out_valid_o  = (state == ST_OUT);
    assign out_pos_o    = (state == ST_OUT) ? mem_rdata[LOGN-1:0] : '0;
    assign out_dummy_o  = (state == ST_OUT) ? mem_rdata[ENTRY_W-1] : 1'b0;
    assign out_last_o   = (state == ST_OUT) && (rd_idx == LAST_IDX);
    assign load_ready_o = load_ready;
    assign count_o      = count;
    assign busy_o       = (state != ST_IDLE);
    assign done_o       = done;
    assign err_o        = err;
    assign dbg_state    = state;

endmodule

// File: tb/tb_sparse_pos_streamer.sv
module tb_sparse_pos_streamer;
    import sparse_pos_streamer_pkg::*;

    localparam int N      = 17669;
    localparam int MW     = 75;
    localparam int STRIDE = 263;
    localparam int LOGN   = $clog2(N);
    localparam int LMW    = $clog2(MW + 1);

    // ---------------- clock / reset / DUT ----------------
    logic            clk;
    logic            rst_n;
    logic            clr_i;
    logic            load_valid_i;
    logic            load_ready_o;
    logic [LOGN-1:0] load_pos_i;
    logic            start_i;
    logic [LOGN-1:0] seed_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [LOGN-1:0] out_pos_o;
    logic            out_dummy_o;
    logic            out_last_o;
    logic [LMW-1:0]  count_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    state_t          dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sparse_pos_streamer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_pos_i   (load_pos_i),
        .start_i      (start_i),
        .seed_i       (seed_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_pos_o    (out_pos_o),
        .out_dummy_o  (out_dummy_o),
        .out_last_o   (out_last_o),
        .count_o      (count_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [LOGN:0]   exp_q[$];
    logic [LOGN-1:0] m_mem [MW];
    int              m_count;
    logic            m_err;
    logic [LOGN:0]   obs [MW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Expected stream: stored real positions in load order, then dummies
    // seed, seed+S, seed+2S ... reduced mod N.
    task automatic build_exp(input int seed);
        longint v;
        exp_q.delete();
        for (int i = 0; i < MW; i++) begin
            if (i < m_count) begin
                exp_q.push_back({1'b0, m_mem[i]});
            end else begin
                v = (longint'(seed) + longint'(i - m_count) * STRIDE) % N;
                exp_q.push_back({1'b1, v[LOGN-1:0]});
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [LOGN-1:0] p, output bit acc);
        @(negedge clk);
        load_valid_i = 1'b1;
        load_pos_i   = p;
        #1;
        acc = load_ready_o;
        @(posedge clk);
        #1;
        load_valid_i = 1'b0;
        if (acc) begin
            if (int'(p) < N) begin
                m_mem[m_count] = p;
                m_count++;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i   = 1'b0;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    task automatic do_start(input int seed);
        @(negedge clk);
        start_i = 1'b1;
        seed_i  = LOGN'(seed);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        build_exp(seed);
    endtask

    // Consume the stream. stop_after < 0 means run to the end and check done.
    task automatic collect(input int stall_at, input int stall_len, input bit rand_bp,
                           input int stop_after);
        int            held;
        int            cycles;
        int            dones;
        int            n_hs;
        int            unstable;
        bit            fin;
        logic [LOGN:0] got;
        logic [LOGN:0] first;
        logic [LOGN:0] req;
        held = 0; cycles = 0; dones = 0; n_hs = 0; unstable = 0; fin = 0;
        first = '0;
        while (!fin && cycles < 3000) begin
            @(negedge clk);
            #1;
            cycles++;
            if (done_o) dones++;
            if (out_valid_o) begin
                got = {out_dummy_o, out_pos_o};
                if (n_hs == stall_at && held < stall_len) begin
                    if (held == 0) first = got;
                    else if (got !== first) unstable++;
                    held++;
                    out_ready_i = 1'b0;
                end else if (rand_bp && $urandom_range(0, 3) == 0) begin
                    out_ready_i = 1'b0;
                end else begin
                    out_ready_i = 1'b1;
                    req = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                    check($sformatf("entry%0d", n_hs), 32'(got), 32'(req));
                    check($sformatf("last%0d", n_hs), 32'(out_last_o), 32'(n_hs == MW - 1));
                    obs[n_hs] = got;
                    n_hs++;
                    if (n_hs == MW || n_hs == stop_after) fin = 1;
                end
            end else begin
                out_ready_i = 1'b0;
            end
        end
        check("stream_timeout", 32'(fin), 32'd1);
        if (stall_len > 0) begin
            check("bp_stable", 32'(unstable), 32'd0);
            check("bp_held", 32'(held), 32'(stall_len));
        end
        if (stop_after < 0) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                #1;
                out_ready_i = 1'b0;
                if (done_o) dones++;
            end
            check("done_once", 32'(dones), 32'd1);
            check("handshakes", 32'(n_hs), 32'(MW));
            check("idle_after", 32'(busy_o), 32'd0);
            check("count_kept", 32'(count_o), 32'(m_count));
        end
    endtask

    // ---------------- table-driven range vectors ----------------
    typedef struct {
        logic [LOGN-1:0] pos;
        bit              exp_acc;
        logic            exp_err;
        int              exp_count;
    } range_vec_t;

    range_vec_t rv[6];

    // ---------------- test sequence ----------------
    initial begin
        bit acc;
        int dsum;
        int nl;
        logic [LOGN-1:0] p;

        rv[0] = '{15'd17669, 1'b1, 1'b1, 0};
        rv[1] = '{15'd17668, 1'b1, 1'b1, 1};
        rv[2] = '{15'd0,     1'b1, 1'b1, 2};
        rv[3] = '{15'd32767, 1'b1, 1'b1, 2};
        rv[4] = '{15'd17667, 1'b1, 1'b1, 3};
        rv[5] = '{15'd17670, 1'b1, 1'b1, 3};

        rst_n = 1'b0; clr_i = 1'b0; load_valid_i = 1'b0; load_pos_i = '0;
        start_i = 1'b0; seed_i = '0; out_ready_i = 1'b0;
        m_count = 0; m_err = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_pos", 32'({out_dummy_o, out_pos_o, out_last_o}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(load_ready_o), 32'd1);

        // Basic: 66 positions 0,10,...,650, seed 100
        for (int i = 0; i < 66; i++) do_load(LOGN'(i * 10), acc);
        check("basic_count", 32'(count_o), 32'd66);
        do_start(100);
        collect(-1, 0, 1'b0, -1);
        check("basic_first_dummy", 32'(obs[66]), 32'({1'b1, 15'd100}));
        check("basic_second_dummy", 32'(obs[67]), 32'({1'b1, 15'd363}));
        check("basic_last_dummy", 32'(obs[74]), 32'({1'b1, 15'd2204}));
        check("basic_last_real", 32'(obs[65]), 32'({1'b0, 15'd650}));

        // Restream with a new seed: real entries kept, pad redone
        do_start(5000);
        collect(-1, 0, 1'b1, -1);
        check("restream_dummy", 32'(obs[66]), 32'({1'b1, 15'd5000}));

        // Wrap with count 74
        do_clr();
        for (int i = 0; i < 74; i++) do_load(LOGN'(i + 7), acc);
        do_start(17600);
        collect(-1, 0, 1'b0, -1);
        check("wrap74_dummy", 32'(obs[74]), 32'({1'b1, 15'd17600}));

        // Wrap with count 73
        do_clr();
        for (int i = 0; i < 73; i++) do_load(LOGN'(i * 3), acc);
        do_start(17600);
        collect(-1, 0, 1'b0, -1);
        check("wrap73_a", 32'(obs[73]), 32'({1'b1, 15'd17600}));
        check("wrap73_b", 32'(obs[74]), 32'({1'b1, 15'd194}));

        // Range table
        do_clr();
        for (int i = 0; i < 6; i++) begin
            do_load(rv[i].pos, acc);
            check($sformatf("range_acc%0d", i), 32'(acc), 32'(rv[i].exp_acc));
            check($sformatf("range_err%0d", i), 32'(err_o), 32'(rv[i].exp_err));
            check($sformatf("range_cnt%0d", i), 32'(count_o), 32'(rv[i].exp_count));
        end
        do_clr();
        check("clr_count", 32'(count_o), 32'd0);
        check("clr_err", 32'(err_o), 32'd0);

        // Full RAM: ready drops after the 75th, no padding
        for (int i = 0; i < MW; i++) do_load(LOGN'(i * 100 + 1), acc);
        check("full_ready", 32'(load_ready_o), 32'd0);
        check("full_count", 32'(count_o), 32'(MW));
        do_load(15'd5, acc);
        check("full_reject", 32'(acc), 32'd0);
        do_start(1234);
        collect(-1, 0, 1'b0, -1);
        dsum = 0;
        for (int i = 0; i < MW; i++) dsum += int'(obs[i][LOGN]);
        check("full_no_dummy", 32'(dsum), 32'd0);

        // Backpressure: stall 5 cycles at entry 3
        do_clr();
        for (int i = 0; i < 40; i++) do_load(LOGN'(i * 17 + 2), acc);
        do_start(42);
        collect(3, 5, 1'b0, -1);

        // Priority: start and load in the same cycle
        do_clr();
        for (int i = 0; i < 10; i++) do_load(LOGN'(i + 1), acc);
        @(negedge clk);
        start_i = 1'b1; seed_i = 15'd900;
        load_valid_i = 1'b1; load_pos_i = 15'd555;
        #1;
        check("prio_ready", 32'(load_ready_o), 32'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0; load_valid_i = 1'b0;
        check("prio_count", 32'(count_o), 32'd10);
        check("prio_busy", 32'(busy_o), 32'd1);
        build_exp(900);
        collect(-1, 0, 1'b0, -1);

        // Loads ignored while busy
        do_start(77);
        do_load(15'd9, acc);
        check("busy_load_ignored", 32'(acc), 32'd0);
        collect(-1, 0, 1'b0, -1);

        // Reset mid-stream at entry 20
        do_start(300);
        collect(-1, 0, 1'b0, 20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_count", 32'(count_o), 32'd0);
        out_ready_i = 1'b0;
        m_count = 0; m_err = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized rounds against the model
        for (int r = 0; r < 5; r++) begin
            do_clr();
            nl = $urandom_range(0, MW);
            for (int i = 0; i < nl; i++) begin
                if ($urandom_range(0, 7) == 0) p = LOGN'($urandom_range(32767, N));
                else p = LOGN'($urandom_range(N - 1, 0));
                do_load(p, acc);
            end
            check("rand_count", 32'(count_o), 32'(m_count));
            check("rand_err", 32'(err_o), 32'(m_err));
            do_start(int'($urandom_range(N - 1, 0)));
            collect(-1, 0, 1'b1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sparse_pos_streamer.md
Name: sparse_pos_streamer

Overview:
- Successor to the single-shot position-RAM loader for the sparse polynomial multiplier.
- Accepts up to MAX_WEIGHT sparse positions through a valid/ready handshake and range-checks each one against N.
- On start, pads the unused RAM slots with deterministic dummy positions, flagged as dummy, so every run streams exactly MAX_WEIGHT entries.
- Sits between the host load interface and the multiplier datapath.

Parameters:
- N, 17669, polynomial length; valid positions are 0..N-1.
- MAX_WEIGHT, 75, RAM depth and fixed stream length.
- LOGN, `CLOG2(N), position width.
- LOG_MAX_WEIGHT, `CLOG2(MAX_WEIGHT+1), count/address width.
- DUMMY_STRIDE, 263, increment between dummy positions; must be < N.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clr_i  in  1  clear position count (honoured in IDLE only)
- load_valid_i  in  1  position offered
- load_ready_o  out  1  position can be accepted
- load_pos_i  in  LOGN  position value
- start_i  in  1  begin pad+stream (IDLE only)
- seed_i  in  LOGN  first dummy position; sampled on start_i
- out_valid_o  out  1  stream entry valid
- out_ready_i  in  1  consumer accepts entry
- out_pos_o  out  LOGN  streamed position
- out_dummy_o  out  1  entry is dummy
- out_last_o  out  1  entry index MAX_WEIGHT-1
- count_o  out  LOG_MAX_WEIGHT  real positions stored
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse after last handshake
- err_o  out  1  sticky: rejected out-of-range load

Behaviour:
- Reset (async, rst_n=0): state IDLE, count 0, all outputs 0. RAM contents are not cleared; count governs validity.
- RAM: one mem_single instance, WIDTH LOGN+1 ({dummy,pos}), DEPTH MAX_WEIGHT, 1-cycle read latency.
- load_ready_o = (state==IDLE) && count<MAX_WEIGHT && !start_i && !clr_i.
- Accepted load with pos<N: writes {0,pos} at address count; count++.
- Accepted load with pos>=N: handshake completes, nothing is written, count is unchanged, err_o set.
- IDLE priority: clr_i > start_i > load. clr_i zeroes count and err_o.
- FSM states:
  - IDLE: start_i -> PAD; dummy register loads seed_i; pad index = count.
  - PAD: one write per cycle of {1,dummy} at pad index; then dummy = dummy+DUMMY_STRIDE, minus N if the sum is >= N (single conditional subtract). Stay in PAD until index MAX_WEIGHT-1 is written, then go to RD with read index 0. If count==MAX_WEIGHT on entry, PAD performs zero writes and passes straight to RD next cycle.
  - RD: issue read at read index -> OUT.
  - OUT: out_valid_o=1 with registered RAM data. out_last_o = (index==MAX_WEIGHT-1). Hold all outputs stable until out_ready_i. On handshake: if last, pulse done_o and go to IDLE; else index++ and go to RD.
- Throughput: at most one entry per 2 cycles. out_valid_o is never asserted outside OUT.
- count_o is retained after a run. A second start re-pads slots count..MAX_WEIGHT-1 with the new seed and restreams; real entries are unchanged.
- load/clr/start are ignored while busy.
- rst_n asserted mid-PAD or mid-stream aborts immediately to IDLE with count 0.
- Dummy positions are always < N provided seed_i < N. seed_i >= N is out of contract; no check is made.

Decomposition:
- Shared package/header holds the FSM state encodings (IDLE, PAD, RD, OUT) and the RAM entry layout (dummy bit at MSB).
- Reuse the existing mem_single as the only sub-module.
- Modular dummy stepping stays inline.

Test Plan:
- Reset then load 66 positions 0,10,...,650; start with seed 100 -> count_o=66, stream of 75 entries: 66 real in load order with dummy=0, then 9 dummies 100,363,626,...,2204 with dummy=1; out_last_o on entry 74; done_o pulses once.
- Wrap: count 74, seed 17600 -> dummy entry 74 = 17600 only. With count 73 -> dummies 17600 then 194.
- Range: load 17669 -> err_o=1, count unchanged. Load 17668 -> accepted. clr_i -> count 0, err_o 0.
- Full: load 75 positions -> load_ready_o drops after the 75th. Start -> zero pad writes, 75 real entries, none dummy.
- Backpressure: hold out_ready_i low for 5 cycles at entry 3 -> out_pos_o/out_dummy_o stable, no skipped or duplicated entries; total 75 handshakes.
- Priority and reset: start_i and load_valid_i in the same cycle -> load not accepted. rst_n pulsed mid-stream at entry 20 -> busy_o, out_valid_o, count_o go 0 immediately.
